// File: rtl/rps_score_keeper.sv
// Rock-paper-scissors match score keeper: counts round results from the game
// core, detects the match winner and drives a multiplexed 7-segment digit.
module rps_score_keeper #(
    parameter int unsigned WIN_TARGET = 3,
    parameter int unsigned DISP_DIV   = 10
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic       res_valid,
    input  logic [1:0] res_code,
    output logic       res_ready,
    input  logic       new_match,
    output logic [3:0] score_p1,
    output logic [3:0] score_p2,
    output logic [3:0] draws,
    output logic       match_over,
    output logic [1:0] match_winner,
    output logic       err,
    output logic [6:0] seg,
    output logic       seg_sel
);

    localparam int unsigned DW     = DISP_DIV;
    localparam logic [3:0]  TARGET = 4'(WIN_TARGET);

    localparam logic [0:0] ST_PLAY = 1'b0;
    localparam logic [0:0] ST_DONE = 1'b1;

    localparam logic [1:0] RES_DRAW = 2'b00;
    localparam logic [1:0] RES_P1   = 2'b01;
    localparam logic [1:0] RES_P2   = 2'b10;

    logic [0:0]    r_state,  w_state_nxt;
    logic [3:0]    r_p1,     w_p1_nxt;
    logic [3:0]    r_p2,     w_p2_nxt;
    logic [3:0]    r_draws,  w_draws_nxt;
    logic          r_over,   w_over_nxt;
    logic [1:0]    r_winner, w_winner_nxt;
    logic          r_err,    w_err_nxt;
    logic [DW-1:0] r_div,    w_div_nxt;
    logic          r_sel,    w_sel_nxt;

    logic       w_ready;
    logic       w_xfer;
    logic [3:0] w_digit;
    logic [6:0] w_seg;

    assign w_ready = ena && (r_state == ST_PLAY) && !new_match;
    assign w_xfer  = res_valid && w_ready;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= ST_PLAY;
            r_p1     <= 4'd0;
            r_p2     <= 4'd0;
            r_draws  <= 4'd0;
            r_over   <= 1'b0;
            r_winner <= 2'b00;
            r_err    <= 1'b0;
            r_div    <= '0;
            r_sel    <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_p1     <= w_p1_nxt;
            r_p2     <= w_p2_nxt;
            r_draws  <= w_draws_nxt;
            r_over   <= w_over_nxt;
            r_winner <= w_winner_nxt;
            r_err    <= w_err_nxt;
            r_div    <= w_div_nxt;
            r_sel    <= w_sel_nxt;
        end
    end

    // Next-state: new_match outranks a result; reaching TARGET ends the match
    always_comb begin
        w_state_nxt  = r_state;
        w_p1_nxt     = r_p1;
        w_p2_nxt     = r_p2;
        w_draws_nxt  = r_draws;
        w_over_nxt   = r_over;
        w_winner_nxt = r_winner;
        w_err_nxt    = r_err;
        w_div_nxt    = r_div;
        w_sel_nxt    = r_sel;

        if (ena) begin
            w_div_nxt = r_div + DW'(1);
            if (r_div == '1) begin
                w_sel_nxt = ~r_sel;
            end

            if (new_match) begin
                w_state_nxt  = ST_PLAY;
                w_p1_nxt     = 4'd0;
                w_p2_nxt     = 4'd0;
                w_draws_nxt  = 4'd0;
                w_over_nxt   = 1'b0;
                w_winner_nxt = 2'b00;
                w_err_nxt    = 1'b0;
            end else if (w_xfer) begin
                case (res_code)
                    RES_DRAW: begin
                        if (r_draws != 4'hF) begin
                            w_draws_nxt = r_draws + 4'd1;
                        end
                    end
                    RES_P1: begin
                        w_p1_nxt = r_p1 + 4'd1;
                        if ((r_p1 + 4'd1) == TARGET) begin
                            w_state_nxt  = ST_DONE;
                            w_over_nxt   = 1'b1;
                            w_winner_nxt = RES_P1;
                        end
                    end
                    RES_P2: begin
                        w_p2_nxt = r_p2 + 4'd1;
                        if ((r_p2 + 4'd1) == TARGET) begin
                            w_state_nxt  = ST_DONE;
                            w_over_nxt   = 1'b1;
                            w_winner_nxt = RES_P2;
                        end
                    end
                    default: begin
                        w_err_nxt = 1'b1;
                    end
                endcase
            end
        end
    end

    // Digit decode of the selected score, blanked on alternate half-periods once won
    always_comb begin
        w_digit = r_sel ? r_p2 : r_p1;
        case (w_digit)
            4'd0:    w_seg = 7'b0111111;
            4'd1:    w_seg = 7'b0000110;
            4'd2:    w_seg = 7'b1011011;
            4'd3:    w_seg = 7'b1001111;
            4'd4:    w_seg = 7'b1100110;
            4'd5:    w_seg = 7'b1101101;
            4'd6:    w_seg = 7'b1111101;
            4'd7:    w_seg = 7'b0000111;
            4'd8:    w_seg = 7'b1111111;
            4'd9:    w_seg = 7'b1101111;
            default: w_seg = 7'b0000000;
        endcase
        if ((r_state == ST_DONE) && r_div[DW-1]) begin
            w_seg = 7'b0000000;
        end
    end

    assign res_ready    = w_ready;
    assign score_p1     = r_p1;
    assign score_p2     = r_p2;
    assign draws        = r_draws;
    assign match_over   = r_over;
    assign match_winner = r_winner;
    assign err          = r_err;
    assign seg          = w_seg;
    assign seg_sel      = r_sel;

endmodule

// File: tb/tb_rps_score_keeper.sv
// Directed bench for rps_score_keeper: vector table for the scoring flow plus
// hand sequences for reset, saturation, enable freeze and the display mux.
module tb_rps_score_keeper;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ena;
    logic       res_valid;
    logic [1:0] res_code;
    logic       res_ready;
    logic       new_match;
    logic [3:0] score_p1;
    logic [3:0] score_p2;
    logic [3:0] draws;
    logic       match_over;
    logic [1:0] match_winner;
    logic       err;
    logic [6:0] seg;
    logic       seg_sel;

    int errors = 0;
    int checks = 0;

    rps_score_keeper #(.WIN_TARGET(3), .DISP_DIV(2)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .ena          (ena),
        .res_valid    (res_valid),
        .res_code     (res_code),
        .res_ready    (res_ready),
        .new_match    (new_match),
        .score_p1     (score_p1),
        .score_p2     (score_p2),
        .draws        (draws),
        .match_over   (match_over),
        .match_winner (match_winner),
        .err          (err),
        .seg          (seg),
        .seg_sel      (seg_sel)
    );

    always #5 clk = ~clk;

    // Reference divider: counts enabled cycles mod 4, select flips on wrap
    logic [1:0] m_div;
    logic       m_sel;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_div <= 2'd0;
            m_sel <= 1'b0;
        end else if (ena) begin
            m_div <= m_div + 2'd1;
            if (m_div == 2'd3) m_sel <= ~m_sel;
        end
    end

    function automatic logic [6:0] enc(input logic [3:0] d);
        case (d)
            4'd0:    enc = 7'b0111111;
            4'd1:    enc = 7'b0000110;
            4'd2:    enc = 7'b1011011;
            4'd3:    enc = 7'b1001111;
            4'd4:    enc = 7'b1100110;
            4'd5:    enc = 7'b1101101;
            4'd6:    enc = 7'b1111101;
            4'd7:    enc = 7'b0000111;
            4'd8:    enc = 7'b1111111;
            4'd9:    enc = 7'b1101111;
            default: enc = 7'b0000000;
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cyc(input logic e, input logic nm, input logic v, input logic [1:0] c);
        @(negedge clk);
        ena       = e;
        new_match = nm;
        res_valid = v;
        res_code  = c;
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic       e;
        logic       nm;
        logic       v;
        logic [1:0] c;
        logic       rdy;
        logic [3:0] p1;
        logic [3:0] p2;
        logic [3:0] d;
        logic       over;
        logic [1:0] win;
        logic       er;
    } vec_t;

    vec_t tbl[11];
    logic sel_before;

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        //              e  nm v  code  rdy p1    p2    d     over win    err
        tbl[0]  = '{1'b1,1'b0,1'b1,2'b01,1'b1,4'd1,4'd0,4'd0,1'b0,2'b00,1'b0};
        tbl[1]  = '{1'b1,1'b0,1'b1,2'b01,1'b1,4'd2,4'd0,4'd0,1'b0,2'b00,1'b0};
        tbl[2]  = '{1'b1,1'b0,1'b1,2'b01,1'b1,4'd3,4'd0,4'd0,1'b1,2'b01,1'b0};
        tbl[3]  = '{1'b1,1'b0,1'b1,2'b10,1'b0,4'd3,4'd0,4'd0,1'b1,2'b01,1'b0};
        tbl[4]  = '{1'b1,1'b1,1'b0,2'b00,1'b0,4'd0,4'd0,4'd0,1'b0,2'b00,1'b0};
        tbl[5]  = '{1'b1,1'b0,1'b1,2'b11,1'b1,4'd0,4'd0,4'd0,1'b0,2'b00,1'b1};
        tbl[6]  = '{1'b1,1'b0,1'b1,2'b10,1'b1,4'd0,4'd1,4'd0,1'b0,2'b00,1'b1};
        tbl[7]  = '{1'b1,1'b0,1'b1,2'b00,1'b1,4'd0,4'd1,4'd1,1'b0,2'b00,1'b1};
        tbl[8]  = '{1'b1,1'b0,1'b1,2'b10,1'b1,4'd0,4'd2,4'd1,1'b0,2'b00,1'b1};
        tbl[9]  = '{1'b1,1'b1,1'b1,2'b10,1'b0,4'd0,4'd0,4'd0,1'b0,2'b00,1'b0};
        tbl[10] = '{1'b0,1'b0,1'b1,2'b01,1'b0,4'd0,4'd0,4'd0,1'b0,2'b00,1'b0};

        rst_n = 1'b0; ena = 1'b0; new_match = 1'b0; res_valid = 1'b0; res_code = 2'b00;
        #3;
        chk("rst_p1", 32'(score_p1), 0);
        chk("rst_p2", 32'(score_p2), 0);
        chk("rst_draws", 32'(draws), 0);
        chk("rst_over", 32'(match_over), 0);
        chk("rst_winner", 32'(match_winner), 0);
        chk("rst_err", 32'(err), 0);
        chk("rst_seg_sel", 32'(seg_sel), 0);
        chk("rst_seg", 32'(seg), 32'(7'b0111111));
        chk("rst_ready", 32'(res_ready), 0);

        // Scoring flow; row 0 lands on the first edge after reset release
        for (int i = 0; i < 11; i++) begin
            @(negedge clk);
            rst_n     = 1'b1;
            ena       = tbl[i].e;
            new_match = tbl[i].nm;
            res_valid = tbl[i].v;
            res_code  = tbl[i].c;
            #1;
            chk($sformatf("v%0d_ready", i), 32'(res_ready), 32'(tbl[i].rdy));
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_p1", i), 32'(score_p1), 32'(tbl[i].p1));
            chk($sformatf("v%0d_p2", i), 32'(score_p2), 32'(tbl[i].p2));
            chk($sformatf("v%0d_draws", i), 32'(draws), 32'(tbl[i].d));
            chk($sformatf("v%0d_over", i), 32'(match_over), 32'(tbl[i].over));
            chk($sformatf("v%0d_winner", i), 32'(match_winner), 32'(tbl[i].win));
            chk($sformatf("v%0d_err", i), 32'(err), 32'(tbl[i].er));
        end

        // Reset asserted while a P1 result is on offer discards it
        cyc(1'b1, 1'b1, 1'b0, 2'b00);
        cyc(1'b1, 1'b0, 1'b1, 2'b01);
        chk("pre_rst_p1", 32'(score_p1), 1);
        @(negedge clk);
        res_valid = 1'b1; res_code = 2'b01; ena = 1'b1; new_match = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_p1", 32'(score_p1), 0);
        chk("async_rst_seg", 32'(seg), 32'(7'b0111111));
        @(posedge clk);
        #1;
        chk("held_rst_p1", 32'(score_p1), 0);
        @(negedge clk);
        rst_n = 1'b1; res_valid = 1'b0;

        // Draw saturation
        for (int i = 0; i < 17; i++) begin
            cyc(1'b1, 1'b0, 1'b1, 2'b00);
            chk($sformatf("draw%0d", i), 32'(draws), (i + 1 > 15) ? 15 : i + 1);
        end
        chk("draw_p1", 32'(score_p1), 0);
        chk("draw_p2", 32'(score_p2), 0);
        chk("draw_over", 32'(match_over), 0);

        // Enable low freezes everything
        sel_before = m_sel;
        for (int i = 0; i < 50; i++) begin
            cyc(1'b0, 1'b0, 1'b1, 2'b01);
            if (res_ready !== 1'b0) chk("frz_ready", 32'(res_ready), 0);
        end
        chk("frz_ready_end", 32'(res_ready), 0);
        chk("frz_p1", 32'(score_p1), 0);
        chk("frz_draws", 32'(draws), 15);
        chk("frz_seg_sel", 32'(seg_sel), 32'(sel_before));

        // Display mux with P1=1, P2=2
        cyc(1'b1, 1'b1, 1'b0, 2'b00);
        cyc(1'b1, 1'b0, 1'b1, 2'b01);
        cyc(1'b1, 1'b0, 1'b1, 2'b10);
        cyc(1'b1, 1'b0, 1'b1, 2'b10);
        chk("disp_p2", 32'(score_p2), 2);
        for (int i = 0; i < 12; i++) begin
            cyc(1'b1, 1'b0, 1'b0, 2'b00);
            chk($sformatf("disp_sel%0d", i), 32'(seg_sel), 32'(m_sel));
            chk($sformatf("disp_seg%0d", i), 32'(seg), 32'(enc(m_sel ? 4'd2 : 4'd1)));
        end

        // P2 wins; digits blink off while divider MSB is set
        cyc(1'b1, 1'b0, 1'b1, 2'b10);
        chk("win_over", 32'(match_over), 1);
        chk("win_winner", 32'(match_winner), 32'(2'b10));
        for (int i = 0; i < 8; i++) begin
            cyc(1'b1, 1'b0, 1'b1, 2'b01);
            chk($sformatf("blink_ready%0d", i), 32'(res_ready), 0);
            chk($sformatf("blink_seg%0d", i), 32'(seg),
                m_div[1] ? 0 : 32'(enc(m_sel ? 4'd3 : 4'd1)));
        end
        chk("done_p1_frozen", 32'(score_p1), 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
